// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard scoreboard:
//   REG_W          register index width
//   FWD_NONE       forward-select value meaning "read the register file"
//   DEPTH_* /
//   LOAD_LAT_*     legal parameter ranges (LOAD_LAT upper bound depends on DEPTH)
//   sb_entry_t     one in-flight position of the scoreboard
//   producer_match helper: does an in-flight entry produce a given source?
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int REG_W        = 5;
   localparam int FWD_NONE     = 0;

   localparam int DEPTH_MIN    = 3;
   localparam int DEPTH_MAX    = 8;
   localparam int LOAD_LAT_MIN = 0;

   // A load must still be able to forward from the last position, so its
   // extra latency can use at most DEPTH-2 positions beyond EX.
   function automatic int load_lat_max(input int depth);
      return depth - 2;
   endfunction

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             wr;
      logic             is_load;
      logic [REG_W-1:0] src_a;
      logic [REG_W-1:0] src_b;
      logic             a_used;
      logic             b_used;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   // Register 0 is hard-wired, so a write to it never produces a value.
   function automatic logic producer_match(input sb_entry_t        e,
                                           input logic [REG_W-1:0] src,
                                           input logic             used);
      return e.valid && e.wr && used && (e.rd != '0) && (e.rd == src);
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_scoreboard_if.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard_if
// Bundle of the decode-side request and scoreboard responses.
//   master : the decode stage (drives the ID instruction fields and flush,
//            observes stall/issue/forward selects/status)
//   slave  : the scoreboard (the reverse directions)
// Handshake: the ID instruction is offered while id_valid=1; it is accepted
// into EX exactly on a rising edge where issue=1. While stall=1 the decode
// stage must hold the same instruction; flush withdraws it without issue.
// -----------------------------------------------------------------------------
interface pipe_scoreboard_if
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int SELW  = $clog2(DEPTH + 1)
);

   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic             id_rs_used;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_reg_wr;
   logic             id_is_load;
   logic             flush;
   logic             stall;
   logic             issue;
   logic [SELW-1:0]  fwd_a_sel;
   logic [SELW-1:0]  fwd_b_sel;
   logic [DEPTH-1:0] pos_valid;
   logic [15:0]      stall_count;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rs2, id_rs2_used,
             id_rd, id_reg_wr, id_is_load, flush,
      input  stall, issue, fwd_a_sel, fwd_b_sel, pos_valid, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rs2, id_rs2_used,
             id_rd, id_reg_wr, id_is_load, flush,
      output stall, issue, fwd_a_sel, fwd_b_sel, pos_valid, stall_count
   );

endinterface : pipe_scoreboard_if

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Comparator for one source operand against every in-flight position.
//   pos_i        in-flight entries, index k-1 = position k (1 = EX)
//   id_src_i     source index of the instruction in ID
//   id_used_i    that source is read
//   ex_src_i     same source of the instruction in EX (position 1)
//   ex_used_i    EX source is read and position 1 is valid
//   fwd_match_o  bit k-1: position k may forward its result to EX now
//   hazard_o     bit p-1: load at position p cannot reach the ID consumer
//                in time, so ID must stall
// -----------------------------------------------------------------------------
module sb_match
   import pipe_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1
) (
   input  sb_entry_t        pos_i [DEPTH],
   input  logic [REG_W-1:0] id_src_i,
   input  logic             id_used_i,
   input  logic [REG_W-1:0] ex_src_i,
   input  logic             ex_used_i,
   output logic [DEPTH-1:0] fwd_match_o,
   output logic [DEPTH-1:0] hazard_o
);

   always_comb begin
      fwd_match_o = '0;
      hazard_o    = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         // After the ID instruction issues, a producer now at position k sits
         // at k+1; a load there only has data when k+1 >= 2+LOAD_LAT.
         if (k <= LOAD_LAT) begin
            hazard_o[k-1] = pos_i[k-1].is_load &&
                            producer_match(pos_i[k-1], id_src_i, id_used_i);
         end
         // Position 1 is the consumer itself; loads too young have no data.
         if (k >= 2 && !(pos_i[k-1].is_load && (k < 2 + LOAD_LAT))) begin
            fwd_match_o[k-1] = producer_match(pos_i[k-1], ex_src_i, ex_used_i);
         end
      end
   end

endmodule : sb_match

// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
// In-order pipeline hazard scoreboard: tracks DEPTH in-flight positions after
// ID, stalls ID on a load-use hazard and selects forwarding sources for EX.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_*              instruction currently in ID (fields already decoded)
//   flush             taken branch/jump squashes the ID instruction
//   stall             freeze PC and IF/ID; a bubble enters EX
//   issue             ID instruction enters position 1 at the next edge
//   fwd_a_sel/_b_sel  EX operand source: 0 = register file, k = position k
//   pos_valid         bit k-1 = position k holds a valid instruction
//   stall_count       saturating count of stall cycles
// -----------------------------------------------------------------------------
module pipe_scoreboard
   import pipe_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   parameter int SELW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_used,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_wr,
   input  logic             id_is_load,
   input  logic             flush,
   output logic             stall,
   output logic             issue,
   output logic [SELW-1:0]  fwd_a_sel,
   output logic [SELW-1:0]  fwd_b_sel,
   output logic [DEPTH-1:0] pos_valid,
   output logic [15:0]      stall_count
);

   // ---------------------------------------------------------------- checks
   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $fatal(1, "pipe_scoreboard: DEPTH=%0d outside %0d..%0d",
             DEPTH, DEPTH_MIN, DEPTH_MAX);
   end
   if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > load_lat_max(DEPTH)) begin : g_bad_lat
      $fatal(1, "pipe_scoreboard: LOAD_LAT=%0d outside %0d..%0d",
             LOAD_LAT, LOAD_LAT_MIN, load_lat_max(DEPTH));
   end

   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   // ----------------------------------------------------------------- state
   sb_entry_t        pos_q [DEPTH];
   sb_entry_t        pos_d [DEPTH];
   logic [15:0]      stall_count_q;
   logic [15:0]      stall_count_d;

   sb_entry_t        id_entry;
   logic [DEPTH-1:0] fwd_match_a;
   logic [DEPTH-1:0] fwd_match_b;
   logic [DEPTH-1:0] hazard_a;
   logic [DEPTH-1:0] hazard_b;
   logic             hazard;

   // ------------------------------------------------------------ comparators
   sb_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
   ) u_match_a (
      .pos_i       (pos_q),
      .id_src_i    (id_rs),
      .id_used_i   (id_rs_used),
      .ex_src_i    (pos_q[0].src_a),
      .ex_used_i   (pos_q[0].valid & pos_q[0].a_used),
      .fwd_match_o (fwd_match_a),
      .hazard_o    (hazard_a)
   );

   sb_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
   ) u_match_b (
      .pos_i       (pos_q),
      .id_src_i    (id_rs2),
      .id_used_i   (id_rs2_used),
      .ex_src_i    (pos_q[0].src_b),
      .ex_used_i   (pos_q[0].valid & pos_q[0].b_used),
      .fwd_match_o (fwd_match_b),
      .hazard_o    (hazard_b)
   );

   // ------------------------------------------------------ stall / issue
   always_comb begin
      hazard = (|hazard_a) | (|hazard_b);
      // Flush dominates: a squashed instruction neither stalls nor issues.
      stall  = id_valid & hazard & ~flush;
      issue  = id_valid & ~hazard & ~flush;
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      id_entry         = SB_BUBBLE;
      id_entry.valid   = 1'b1;
      id_entry.rd      = id_rd;
      id_entry.wr      = id_reg_wr;
      id_entry.is_load = id_is_load;
      id_entry.src_a   = id_rs;
      id_entry.src_b   = id_rs2;
      id_entry.a_used  = id_rs_used;
      id_entry.b_used  = id_rs2_used;

      pos_d[0] = issue ? id_entry : SB_BUBBLE;
      for (int k = 1; k < DEPTH; k++) begin
         pos_d[k] = pos_q[k-1];
      end

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != COUNT_MAX)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            pos_q[k] <= SB_BUBBLE;
         end
         stall_count_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            pos_q[k] <= pos_d[k];
         end
         stall_count_q <= stall_count_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      fwd_a_sel = SELW'(FWD_NONE);
      fwd_b_sel = SELW'(FWD_NONE);
      for (int k = DEPTH; k >= 2; k--) begin
         if (fwd_match_a[k-1]) fwd_a_sel = SELW'(k);
         if (fwd_match_b[k-1]) fwd_b_sel = SELW'(k);
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         pos_valid[k] = pos_q[k].valid;
      end
   end

   assign stall_count = stall_count_q;

endmodule : pipe_scoreboard

// File: tb/tb_pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_scoreboard
// Main instance (DEPTH=3, LOAD_LAT=1): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against an
// instruction-level model of the pipe. A second instance (DEPTH=8,
// LOAD_LAT=6) is driven with a back-to-back dependent load chain to
// saturate stall_count and to reset it mid-stall.
// -----------------------------------------------------------------------------
module tb_pipe_scoreboard;
  import pipe_pkg::*;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int SELW     = $clog2(DEPTH + 1);
  localparam int D2       = 8;
  localparam int L2       = 6;
  localparam int S2       = $clog2(D2 + 1);
  localparam int SAT_CYCLES  = 77000;
  localparam int RAND_CYCLES = 3000;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  pipe_scoreboard_if #(.DEPTH(DEPTH), .SELW(SELW)) sb_if ();
  pipe_scoreboard_if #(.DEPTH(D2), .SELW(S2)) sat_if ();

  pipe_scoreboard #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .reset(reset),
    .id_valid(sb_if.id_valid), .id_rs(sb_if.id_rs), .id_rs_used(sb_if.id_rs_used),
    .id_rs2(sb_if.id_rs2), .id_rs2_used(sb_if.id_rs2_used), .id_rd(sb_if.id_rd),
    .id_reg_wr(sb_if.id_reg_wr), .id_is_load(sb_if.id_is_load), .flush(sb_if.flush),
    .stall(sb_if.stall), .issue(sb_if.issue), .fwd_a_sel(sb_if.fwd_a_sel),
    .fwd_b_sel(sb_if.fwd_b_sel), .pos_valid(sb_if.pos_valid), .stall_count(sb_if.stall_count)
  );

  pipe_scoreboard #(.DEPTH(D2), .LOAD_LAT(L2)) dut_sat (
    .clk(clk), .reset(reset2),
    .id_valid(sat_if.id_valid), .id_rs(sat_if.id_rs), .id_rs_used(sat_if.id_rs_used),
    .id_rs2(sat_if.id_rs2), .id_rs2_used(sat_if.id_rs2_used), .id_rd(sat_if.id_rd),
    .id_reg_wr(sat_if.id_reg_wr), .id_is_load(sat_if.id_is_load), .flush(sat_if.flush),
    .stall(sat_if.stall), .issue(sat_if.issue), .fwd_a_sel(sat_if.fwd_a_sel),
    .fwd_b_sel(sat_if.fwd_b_sel), .pos_valid(sat_if.pos_valid), .stall_count(sat_if.stall_count)
  );

  // ------------------------------------------------------------ bookkeeping
  int vectors = 0;
  int miscompares = 0;
  bit sat_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic set_id(input bit v, input int rs, input bit ru, input int rs2, input bit r2u,
                        input int rd, input bit wr, input bit ld, input bit fl);
    sb_if.id_valid    = v;
    sb_if.id_rs       = 5'(rs);
    sb_if.id_rs_used  = ru;
    sb_if.id_rs2      = 5'(rs2);
    sb_if.id_rs2_used = r2u;
    sb_if.id_rd       = 5'(rd);
    sb_if.id_reg_wr   = wr;
    sb_if.id_is_load  = ld;
    sb_if.flush       = fl;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain();
    set_idle();
    repeat (DEPTH + 1) tick();
  endtask

  // ------------------------------------------------------------------ model
  // The pipe as a list of instructions by age: flight[0] is in EX, flight[i]
  // entered EX i cycles ago. Non-instructions (bubbles) have valid=0.
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
    int ra;
    int rb;
    bit ua;
    bit ub;
  } slot_t;

  slot_t flight[$];
  int    model_count = 0;

  function automatic slot_t bubble();
    slot_t s;
    s.valid = 0; s.rd = 0; s.wr = 0; s.ld = 0; s.ra = 0; s.rb = 0; s.ua = 0; s.ub = 0;
    return s;
  endfunction

  function automatic bit feeds(slot_t p, int r, bit used);
    return p.valid && p.wr && used && (r != 0) && (p.rd == r);
  endfunction

  // Consumer in ID would reach EX next cycle; a load that entered EX 'age-1'
  // cycles ago delivers data only once it is LOAD_LAT stages past EX.
  function automatic bit load_use(int ra, bit ua, int rb, bit ub);
    bit h = 0;
    for (int age = 1; age <= DEPTH; age++) begin
      if (flight[age-1].ld && (age + 1 < 2 + LOAD_LAT) &&
          (feeds(flight[age-1], ra, ua) || feeds(flight[age-1], rb, ub))) h = 1;
    end
    return h;
  endfunction

  function automatic int fwd_from(int r, bit used);
    if (!flight[0].valid) return 0;
    for (int k = 2; k <= DEPTH; k++) begin
      if (feeds(flight[k-1], r, used) && !(flight[k-1].ld && (k - 2 < LOAD_LAT))) return k;
    end
    return 0;
  endfunction

  // ----------------------------------------------------------- compare proc
  bit          e_stall, e_issue;
  int          e_fa, e_fb;
  logic [DEPTH-1:0] e_pv;
  slot_t       id_slot;

  initial begin
    repeat (DEPTH) flight.push_back(bubble());
    forever begin
      @(negedge clk);
      e_stall = sb_if.id_valid && !sb_if.flush &&
                load_use(int'(sb_if.id_rs), sb_if.id_rs_used, int'(sb_if.id_rs2), sb_if.id_rs2_used);
      e_issue = sb_if.id_valid && !e_stall && !sb_if.flush;
      e_fa    = fwd_from(flight[0].ra, flight[0].ua);
      e_fb    = fwd_from(flight[0].rb, flight[0].ub);
      for (int k = 0; k < DEPTH; k++) e_pv[k] = flight[k].valid;

      check("stall", 32'(sb_if.stall), 32'(e_stall));
      check("issue", 32'(sb_if.issue), 32'(e_issue));
      check("fwd_a_sel", 32'(sb_if.fwd_a_sel), 32'(e_fa));
      check("fwd_b_sel", 32'(sb_if.fwd_b_sel), 32'(e_fb));
      check("pos_valid", 32'(sb_if.pos_valid), 32'(e_pv));
      check("stall_count", 32'(sb_if.stall_count), 32'(model_count));

      if (reset) begin
        flight.delete();
        repeat (DEPTH) flight.push_back(bubble());
        model_count = 0;
      end else begin
        if (e_stall && model_count < 65535) model_count++;
        if (e_issue) begin
          id_slot.valid = 1;
          id_slot.rd = int'(sb_if.id_rd);
          id_slot.wr = sb_if.id_reg_wr;
          id_slot.ld = sb_if.id_is_load;
          id_slot.ra = int'(sb_if.id_rs);
          id_slot.rb = int'(sb_if.id_rs2);
          id_slot.ua = sb_if.id_rs_used;
          id_slot.ub = sb_if.id_rs2_used;
          flight.push_front(id_slot);
        end else begin
          flight.push_front(bubble());
        end
        void'(flight.pop_back());
      end
    end
  end

  // ------------------------------------------------- main directed + random
  initial begin
    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    settle();
    check("rst pos_valid", 32'(sb_if.pos_valid), 32'd0);
    check("rst fwd_a", 32'(sb_if.fwd_a_sel), 32'd0);
    check("rst stall_count", 32'(sb_if.stall_count), 32'd0);

    // load r5, then dependent add: one stall, then forward from position 3
    tick();
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
    settle();
    check("lu load issue", 32'(sb_if.issue), 32'd1);
    tick();
    set_id(1, 5, 1, 6, 1, 8, 1, 0, 0);
    settle();
    check("lu stall", 32'(sb_if.stall), 32'd1);
    check("lu no issue", 32'(sb_if.issue), 32'd0);
    tick();
    settle();
    check("lu stall released", 32'(sb_if.stall), 32'd0);
    check("lu add issue", 32'(sb_if.issue), 32'd1);
    check("lu stall_count", 32'(sb_if.stall_count), 32'd1);
    tick();
    set_idle();
    settle();
    check("lu fwd_a", 32'(sb_if.fwd_a_sel), 32'd3);
    check("lu fwd_b", 32'(sb_if.fwd_b_sel), 32'd0);
    check("lu pos_valid", 32'(sb_if.pos_valid), 32'b101);
    drain();

    // ALU r7 then back-to-back consumer on both sources
    set_id(1, 1, 1, 2, 1, 7, 1, 0, 0);
    tick();
    set_id(1, 7, 1, 7, 1, 9, 1, 0, 0);
    settle();
    check("alu no stall", 32'(sb_if.stall), 32'd0);
    tick();
    set_idle();
    settle();
    check("alu fwd_a", 32'(sb_if.fwd_a_sel), 32'd2);
    check("alu fwd_b", 32'(sb_if.fwd_b_sel), 32'd2);
    drain();

    // two producers of r3, youngest forwards
    set_id(1, 1, 1, 0, 0, 3, 1, 0, 0);
    tick();
    set_id(1, 2, 1, 0, 0, 3, 1, 0, 0);
    tick();
    set_id(1, 3, 1, 0, 0, 4, 1, 0, 0);
    tick();
    set_idle();
    settle();
    check("youngest fwd_a", 32'(sb_if.fwd_a_sel), 32'd2);
    drain();

    // load to r0 never creates a dependency
    set_id(1, 1, 1, 0, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0, 0);
    settle();
    check("r0 no stall", 32'(sb_if.stall), 32'd0);
    tick();
    set_idle();
    settle();
    check("r0 fwd_a", 32'(sb_if.fwd_a_sel), 32'd0);
    drain();

    // flush with a hazard: flush wins, counter unchanged
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 8, 1, 0, 1);
    settle();
    check("flush stall", 32'(sb_if.stall), 32'd0);
    check("flush issue", 32'(sb_if.issue), 32'd0);
    tick();
    set_idle();
    settle();
    check("flush pos_valid", 32'(sb_if.pos_valid), 32'b010);
    check("flush stall_count", 32'(sb_if.stall_count), 32'd1);
    drain();

    // reset in the middle of a load-use stall
    set_id(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 8, 1, 0, 0);
    reset = 1'b1;
    settle();
    check("mid rst stall", 32'(sb_if.stall), 32'd1);
    tick();
    reset = 1'b0;
    settle();
    check("post rst stall", 32'(sb_if.stall), 32'd0);
    check("post rst issue", 32'(sb_if.issue), 32'd1);
    check("post rst pos_valid", 32'(sb_if.pos_valid), 32'd0);
    check("post rst stall_count", 32'(sb_if.stall_count), 32'd0);
    tick();
    drain();

    // randomized traffic on a small register set to provoke dependencies
    for (int i = 0; i < RAND_CYCLES; i++) begin
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    set_idle();

    for (int i = 0; i < SAT_CYCLES + 1000 && !sat_done; i++) @(posedge clk);
    if (!sat_done) check("saturation run finished", 32'd0, 32'd1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ------------------------------------------ saturation on deep instance
  // A chain of loads each reading the previous load's destination: every
  // load stalls ID for LOAD_LAT=6 cycles and then issues, so stall is high
  // on all cycles except every 7th, starting with an issue on an empty pipe.
  int  sat_exp_cnt = 0;
  bit  sat_exp_stall;

  initial begin
    sat_if.id_valid = 1'b1;
    sat_if.id_rs = 5'd5;  sat_if.id_rs_used = 1'b1;
    sat_if.id_rs2 = 5'd0; sat_if.id_rs2_used = 1'b0;
    sat_if.id_rd = 5'd5;  sat_if.id_reg_wr = 1'b1;
    sat_if.id_is_load = 1'b1;
    sat_if.flush = 1'b0;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset2 = 1'b0;

    for (int n = 0; n < SAT_CYCLES; n++) begin
      @(negedge clk);
      sat_exp_stall = (n % (L2 + 1)) != 0;
      check("sat stall", 32'(sat_if.stall), 32'(sat_exp_stall));
      if ((n % 4096) == 0) check("sat stall_count", 32'(sat_if.stall_count), 32'(sat_exp_cnt));
      if (n == 7000) check("sat count at 7000", 32'(sat_if.stall_count), 32'd6000);
      if (sat_exp_stall && sat_exp_cnt < 65535) sat_exp_cnt++;
    end

    // last loop cycle is a stall cycle; counter has long since saturated
    check("sat saturated", 32'(sat_if.stall_count), 32'h0000FFFF);
    reset2 = 1'b1;
    @(posedge clk);
    #1 reset2 = 1'b0;
    @(negedge clk);
    check("sat rst pos_valid", 32'(sat_if.pos_valid), 32'd0);
    check("sat rst stall_count", 32'(sat_if.stall_count), 32'd0);
    check("sat rst no stale stall", 32'(sat_if.stall), 32'd0);
    check("sat rst issue", 32'(sat_if.issue), 32'd1);
    sat_done = 1'b1;
  end

endmodule : tb_pipe_scoreboard

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: in-flight positions after ID (position 1 = EX, position DEPTH = WB); legal range 3..8.
REQ-002 Parameter LOAD_LAT, default 1: extra cycles a load result lags an ALU result; legal range 0..DEPTH-2.
REQ-003 Parameter SELW, default clog2(DEPTH+1): forward-select width.
REQ-004 Ports, in this order:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  id_valid  in  1  ID holds a valid instruction
  id_rs  in  5  source A register index
  id_rs_used  in  1  source A is read
  id_rs2  in  5  source B register index
  id_rs2_used  in  1  source B is read
  id_rd  in  5  destination index, already rd/rs2-selected
  id_reg_wr  in  1  instruction writes a register
  id_is_load  in  1  instruction is a load
  flush  in  1  taken branch/jump squashes the ID instruction
  stall  out  1  freeze PC and IF/ID; insert a bubble into EX
  issue  out  1  ID instruction enters position 1 at the next edge
  fwd_a_sel  out  SELW  EX source A: 0 = register file, k = position k result
  fwd_b_sel  out  SELW  same for source B
  pos_valid  out  DEPTH  bit k-1 = position k holds a valid instruction
  stall_count  out  16  saturating count of stall cycles

Function
REQ-005 Each position k holds {valid, rd, wr, is_load, src_a, src_b, a_used, b_used}; every clock the content of position k moves to position k+1, and position DEPTH's content is discarded.
REQ-006 Position 1 loads the ID fields with valid=1 when issue=1; otherwise it loads a bubble (all fields 0).
REQ-007 A producer at position p matches a source when valid, wr, rd==source index, source-used, and rd!=0; register 0 never matches.
REQ-008 hazard=1 when a source matches a producer at position p with is_load=1 and p<=LOAD_LAT; ALU producers never cause a hazard.
REQ-009 stall=id_valid & hazard & !flush, combinational from current state and inputs.
REQ-010 issue=id_valid & !stall & !flush; a flushed ID instruction never enters position 1.
REQ-011 fwd_a_sel and fwd_b_sel are combinational on position 1's sources: the value is the smallest k in 2..DEPTH whose producer matches, else 0; a load producer at k<2+LOAD_LAT is excluded.
REQ-012 fwd_*_sel is 0 when position 1 is a bubble.
REQ-013 flush and stall together: flush wins; stall=0, issue=0, and the bubble enters position 1.
REQ-014 stall_count increments by 1 on each clock with stall=1 and holds at 16'hFFFF.
REQ-015 pos_valid is a direct register output (no combinational path from inputs).
REQ-016 Latency: issue registers into position 1 in 1 cycle; stall and fwd_sel have 0-cycle combinational latency.

Reset
REQ-017 While reset=1 at a clock edge, all positions clear to bubbles and stall_count clears to 0.
REQ-018 After reset, pos_valid=0, fwd_a_sel=0, fwd_b_sel=0, stall_count=0; stall and issue follow REQ-009/REQ-010 with an empty scoreboard.
REQ-019 Reset asserted mid-stall discards all in-flight entries; the next cycle carries no stale hazard.

Structure
REQ-020 Shared package pipe_pkg holds REG_W=5, FWD_NONE=0, the entry struct typedef, and the DEPTH/LOAD_LAT legal-range constants.
REQ-021 One sub-module, sb_match: a per-source comparator across all positions that outputs a match vector and is_load-qualified hazard bits; it is instantiated twice, once per source.
REQ-022 The parameter check is elaborate-time; an illegal DEPTH/LOAD_LAT is a fatal error.

Verification
REQ-023 LOAD_LAT=1: issue a load to r5, then next cycle an add reading r5 -> stall=1 for exactly 1 cycle; the add then enters EX with fwd_a_sel=3, and stall_count=1.
REQ-024 ALU to r7, then back-to-back ALU reading r7 on both sources -> no stall; fwd_a_sel=fwd_b_sel=2.
REQ-025 Producers writing r3 at positions 2 and 3, with the EX consumer reading r3 -> fwd_a_sel=2 (youngest wins).
REQ-026 A load to r0 followed by a consumer reading r0 -> no stall; fwd_a_sel=0.
REQ-027 flush and a hazard in the same cycle -> stall=0, issue=0, position 1 bubble, and stall_count unchanged.
REQ-028 Force 70000 stall cycles -> stall_count=16'hFFFF; then assert reset mid-stall -> pos_valid=0 and stall_count=0 on the next cycle.
